// File: rtl/fifo_word_serializer.sv
// Fetches one word from a registered-read FIFO and transmits it as an
// async-style serial frame. SER_PARITY_EN adds an even-parity bit before STOP.
module fifo_word_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BAUD_DIV   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  ser_out,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef SER_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic                  ser_out_q, ser_out_d;
    logic                  fifo_rd_q, fifo_rd_d;
`ifdef SER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic baud_last;
    logic bit_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable && !fifo_empty) state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  state_d = S_START;
            S_START: if (baud_last) state_d = S_DATA;
            S_DATA: begin
                if (baud_last && bit_last) begin
`ifdef SER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: if (baud_last) state_d = S_STOP;
`endif
            S_STOP:  if (baud_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider restarts on every bit boundary so the frame cannot drift.
    always_comb begin
        baud_cnt_d  = '0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            S_WAIT: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
`ifdef SER_PARITY_EN
                parity_d  = ^fifo_data;
`endif
            end
            S_START: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            end
            S_DATA: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
                if (baud_last) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            end
`endif
            S_STOP: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
                if (baud_last) frame_cnt_d = frame_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Output flops are loaded from next-state values so they align with state_q.
    always_comb begin
        fifo_rd_d = (state_d == S_REQ);
        ser_out_d = 1'b1;
        case (state_d)
            S_START:  ser_out_d = 1'b0;
            S_DATA:   ser_out_d = shift_d[0];
`ifdef SER_PARITY_EN
            S_PARITY: ser_out_d = parity_d;
`endif
            default:  ser_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
            ser_out_q   <= 1'b1;
            fifo_rd_q   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
            ser_out_q   <= ser_out_d;
            fifo_rd_q   <= fifo_rd_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign ser_out   = ser_out_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule
